// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC conversion controller
//
// Samples the analog input through a track/hold switch, then binary-searches
// it one bit per step by driving a trial code into the on-chip DAC and reading
// back an asynchronous comparator bit.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ena        design enable; low aborts or blocks conversions
//   start      conversion request, level-sampled while idle
//   comp_in    asynchronous comparator output (1 = Vin >= Vdac)
//   sample_en  track/hold control (1 = track)
//   dac_code   registered trial code to the DAC
//   busy       high whenever a conversion is in progress (not idle)
//   done       one-cycle pulse when result updates
//   result     last completed conversion, held until the next completion
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             comp_in,
    output logic             sample_en,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // The wait phase also covers the two comparator synchronizer stages, so
    // the sampled bit in DECIDE always reflects the current trial code.
    localparam int WAIT_CYCLES = SETTLE_CYCLES + 2;
    localparam int CNT_MAX     = (SAMPLE_CYCLES > WAIT_CYCLES) ? SAMPLE_CYCLES : WAIT_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CODE_MSB    = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_WAIT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             comp_meta_q, comp_meta_d;
    logic             comp_s_q, comp_s_d;

    logic [WIDTH-1:0] acc_new;
    logic [IDX_W-1:0] idx_m1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        dac_code_d  = dac_code_q;
        result_d    = result_q;
        comp_meta_d = comp_in;
        comp_s_d    = comp_meta_q;

        // The trial code is the accumulator with the bit under test set, so a
        // comparator "1" simply keeps the whole trial code.
        acc_new = comp_s_q ? dac_code_q : acc_q;
        idx_m1  = idx_q - IDX_W'(1);

        case (state_q)
            S_IDLE: begin
                dac_code_d = '0;
                if (start && ena) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    idx_d   = IDX_TOP;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d    = S_WAIT;
                    cnt_d      = '0;
                    dac_code_d = CODE_MSB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_DECIDE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECIDE: begin
                acc_d = acc_new;
                if (idx_q != '0) begin
                    idx_d      = idx_m1;
                    dac_code_d = acc_new | (WIDTH'(1) << idx_m1);
                    state_d    = S_WAIT;
                end else begin
                    result_d   = acc_new;
                    dac_code_d = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                dac_code_d = '0;
                cnt_d      = '0;
            end
        endcase

        // Losing enable mid-conversion discards everything, including a result
        // that would otherwise have been written on this very edge.
        if (state_q != S_IDLE && !ena) begin
            state_d    = S_IDLE;
            dac_code_d = '0;
            cnt_d      = '0;
            result_d   = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            dac_code_q  <= '0;
            result_q    <= '0;
            comp_meta_q <= 1'b0;
            comp_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            dac_code_q  <= dac_code_d;
            result_q    <= result_d;
            comp_meta_q <= comp_meta_d;
            comp_s_q    <= comp_s_d;
        end
    end

    assign sample_en = (state_q == S_SAMPLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dac_code  = dac_code_q;
    assign result    = result_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl
module tb_sar_adc_ctrl;

    localparam int W      = 8;
    localparam int SAMPLE = 4;

    logic         clk;
    logic         rst_n;
    logic         ena;
    logic         start;
    logic         start0;
    logic [W-1:0] vin;
    logic         comp_in;
    logic         comp_in0;

    logic         sample_en, busy, done;
    logic [W-1:0] dac_code, result;
    logic         sample_en0, busy0, done0;
    logic [W-1:0] dac_code0, result0;

    int tests;
    int fails;

    // ideal comparator for each DUT
    assign comp_in  = (vin >= dac_code);
    assign comp_in0 = (vin >= dac_code0);

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SAMPLE), .SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .comp_in(comp_in),
        .sample_en(sample_en), .dac_code(dac_code), .busy(busy), .done(done), .result(result)
    );

    sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SAMPLE), .SETTLE_CYCLES(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start0), .comp_in(comp_in0),
        .sample_en(sample_en0), .dac_code(dac_code0), .busy(busy0), .done(done0), .result(result0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observation mux so one measurement task serves both instances
    bit           sel_s0;
    logic         o_sample_en, o_busy, o_done;
    logic [W-1:0] o_dac, o_result;
    assign o_sample_en = sel_s0 ? sample_en0 : sample_en;
    assign o_busy      = sel_s0 ? busy0      : busy;
    assign o_done      = sel_s0 ? done0      : done;
    assign o_dac       = sel_s0 ? dac_code0  : dac_code;
    assign o_result    = sel_s0 ? result0    : result;

    // result must never move while done is low
    bit           mon_en;
    logic [W-1:0] mon_prev;
    always @(negedge clk) begin
        if (mon_en && rst_n && !done) begin
            tests++;
            if (result !== mon_prev) begin
                fails++;
                $display("FAIL result_stable: got %h required %h at %0t", result, mon_prev, $time);
            end
        end
        mon_prev = result;
    end

    // reference: plain binary search over the ideal comparator
    logic [W-1:0] exp_trials[$];
    task automatic build_model(input logic [W-1:0] v);
        logic [W-1:0] acc;
        logic [W-1:0] trial;
        exp_trials.delete();
        acc = '0;
        for (int b = W - 1; b >= 0; b--) begin
            trial = acc | (W'(1) << b);
            exp_trials.push_back(trial);
            if (v >= trial) acc = trial;
        end
    endtask

    function automatic int exp_done_cyc(input int settle);
        return SAMPLE + W * (settle + 3) + 1;
    endfunction

    function automatic int exp_trial_cyc(input int i, input int settle);
        return SAMPLE + 1 + i * (settle + 3);
    endfunction

    // measurement results of one conversion
    logic [W-1:0] trials[$];
    int           trial_cyc[$];
    int           samp_cnt, done_cyc, done_cnt;
    logic [W-1:0] res_at_done, dac_at_done;
    logic         busy_after;

    // Starts one conversion (aligned just after a posedge, DUT idle) and
    // records what happens; pulse_at > 0 re-pulses start in that cycle.
    task automatic run_conv(input logic [W-1:0] v, input bit use_s0, input int pulse_at);
        logic [W-1:0] prev_code;
        trials.delete();
        trial_cyc.delete();
        samp_cnt = 0; done_cyc = -1; done_cnt = 0;
        res_at_done = '0; dac_at_done = '1; prev_code = '0;
        sel_s0 = use_s0;
        vin = v;
        if (use_s0) start0 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start0 = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (o_sample_en) samp_cnt++;
            if (o_dac != prev_code && o_dac != '0) begin
                trials.push_back(o_dac);
                trial_cyc.push_back(n);
            end
            prev_code = o_dac;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = n;
                    res_at_done = o_result;
                    dac_at_done = o_dac;
                end
            end
            if (pulse_at > 0 && n == pulse_at) begin
                if (use_s0) start0 = 1'b1; else start = 1'b1;
            end
            if (pulse_at > 0 && n == pulse_at + 1) begin
                start = 1'b0; start0 = 1'b0;
            end
            if (done_cyc > 0 && n >= done_cyc + 3) break;
        end
        busy_after = o_busy;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (sample_en !== 1'b0) begin fails++; $display("FAIL rst_sample_en: got %b required 0", sample_en); end
        tests++; if (dac_code !== '0) begin fails++; $display("FAIL rst_dac_code: got %h required 00", dac_code); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", done); end
        tests++; if (result !== '0) begin fails++; $display("FAIL rst_result: got %h required 00", result); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || dac_code !== '0) begin fails++; $display("FAIL post_rst_idle: got busy=%b dac=%h required 0/00", busy, dac_code); end
        @(posedge clk); #1;
    endtask

    task automatic test_ideal_a5();
        build_model(8'hA5);
        run_conv(8'hA5, 1'b0, 0);
        tests++; if (trials.size() != W) begin fails++; $display("FAIL a5_trial_count: got %0d required %0d", trials.size(), W); end
        for (int i = 0; i < W; i++) begin
            tests++; if (trials[i] !== exp_trials[i]) begin fails++; $display("FAIL a5_trial[%0d]: got %h required %h", i, trials[i], exp_trials[i]); end
            tests++; if (trial_cyc[i] != exp_trial_cyc(i, 2)) begin fails++; $display("FAIL a5_trial_cyc[%0d]: got %0d required %0d", i, trial_cyc[i], exp_trial_cyc(i, 2)); end
        end
        tests++; if (done_cyc != 45) begin fails++; $display("FAIL a5_done_cycle: got %0d required 45", done_cyc); end
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL a5_done_pulses: got %0d required 1", done_cnt); end
        tests++; if (res_at_done !== 8'hA5) begin fails++; $display("FAIL a5_result: got %h required a5", res_at_done); end
        tests++; if (samp_cnt != SAMPLE) begin fails++; $display("FAIL a5_sample_len: got %0d required %0d", samp_cnt, SAMPLE); end
    endtask

    task automatic test_extremes();
        run_conv(8'h00, 1'b0, 0);
        tests++; if (res_at_done !== 8'h00) begin fails++; $display("FAIL zero_result: got %h required 00", res_at_done); end
        tests++; if (dac_at_done !== 8'h00) begin fails++; $display("FAIL zero_dac_in_done: got %h required 00", dac_at_done); end
        tests++; if (done_cyc != 45) begin fails++; $display("FAIL zero_done_cycle: got %0d required 45", done_cyc); end
        run_conv(8'hFF, 1'b0, 0);
        tests++; if (res_at_done !== 8'hFF) begin fails++; $display("FAIL ones_result: got %h required ff", res_at_done); end
        tests++; if (dac_at_done !== 8'h00) begin fails++; $display("FAIL ones_dac_in_done: got %h required 00", dac_at_done); end
        tests++; if (result !== 8'hFF) begin fails++; $display("FAIL ones_result_hold: got %h required ff", result); end
    endtask

    task automatic test_back_to_back();
        int           d1, d2, cur_len;
        int           s_rise[$];
        int           s_len[$];
        bit           prev_se, gap_idle;
        logic [W-1:0] r1, r2;
        d1 = -1; d2 = -1; cur_len = 0; prev_se = 1'b0; gap_idle = 1'b0;
        r1 = '0; r2 = '0;
        sel_s0 = 1'b0;
        vin = 8'h3C;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 120 && d2 < 0; n++) begin
            @(negedge clk);
            if (sample_en) begin
                if (!prev_se) s_rise.push_back(n);
                cur_len++;
            end else if (prev_se) begin
                s_len.push_back(cur_len);
                cur_len = 0;
            end
            prev_se = sample_en;
            if (d1 > 0 && n == d1 + 1) gap_idle = !busy;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n; r1 = result; vin = 8'hC3;
                end else begin
                    d2 = n; r2 = result; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        tests++; if (r1 !== 8'h3C) begin fails++; $display("FAIL b2b_result1: got %h required 3c", r1); end
        tests++; if (r2 !== 8'hC3) begin fails++; $display("FAIL b2b_result2: got %h required c3", r2); end
        tests++; if (d1 != 45) begin fails++; $display("FAIL b2b_done1_cycle: got %0d required 45", d1); end
        tests++; if (d2 != 91) begin fails++; $display("FAIL b2b_done2_cycle: got %0d required 91", d2); end
        tests++; if (!gap_idle) begin fails++; $display("FAIL b2b_idle_gap: got busy in gap cycle, required idle"); end
        tests++; if (s_rise.size() != 2 || s_rise[1] != d1 + 2) begin fails++; $display("FAIL b2b_second_sample: got %0d rises, second at %0d, required 2 rises, second at %0d", s_rise.size(), (s_rise.size() > 1) ? s_rise[1] : -1, d1 + 2); end
        tests++; if (s_len.size() != 2 || s_len[0] != SAMPLE || s_len[1] != SAMPLE) begin fails++; $display("FAIL b2b_sample_len: got %0d windows, required 2 of %0d cycles", s_len.size(), SAMPLE); end
    endtask

    task automatic test_abort();
        bit saw_done;
        run_conv(8'h55, 1'b0, 0);
        tests++; if (res_at_done !== 8'h55) begin fails++; $display("FAIL abort_pre_result: got %h required 55", res_at_done); end
        build_model(8'hAA);
        vin = 8'hAA;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) @(negedge clk);
        // cycle 16 lies in the wait phase of bit 5
        tests++; if (dac_code !== exp_trials[2] || !busy) begin fails++; $display("FAIL abort_bit5_wait: got dac=%h busy=%b required %h/1", dac_code, busy, exp_trials[2]); end
        ena = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b required 0", busy); end
        tests++; if (dac_code !== '0 || sample_en !== 1'b0) begin fails++; $display("FAIL abort_outputs: got dac=%h se=%b required 00/0", dac_code, sample_en); end
        tests++; if (result !== 8'h55) begin fails++; $display("FAIL abort_result: got %h required 55", result); end
        saw_done = 1'b0;
        start = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        start = 1'b0;
        tests++; if (saw_done) begin fails++; $display("FAIL abort_blocked: got activity while disabled, required none"); end
        ena = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        vin = 8'h77;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mon_en = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || sample_en !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midrst_ctrl: got busy=%b se=%b done=%b required 0/0/0", busy, sample_en, done); end
        tests++; if (dac_code !== '0 || result !== '0) begin fails++; $display("FAIL midrst_data: got dac=%h result=%h required 00/00", dac_code, result); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        run_conv(8'h12, 1'b0, 0);
        tests++; if (res_at_done !== 8'h12) begin fails++; $display("FAIL midrst_reconvert: got %h required 12", res_at_done); end
        tests++; if (done_cyc != 45) begin fails++; $display("FAIL midrst_done_cycle: got %0d required 45", done_cyc); end
    endtask

    task automatic test_busy_ignore();
        run_conv(8'h6B, 1'b0, 20);
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL busy_start_pulses: got %0d done pulses required 1", done_cnt); end
        tests++; if (done_cyc != 45) begin fails++; $display("FAIL busy_start_done_cycle: got %0d required 45", done_cyc); end
        tests++; if (res_at_done !== 8'h6B) begin fails++; $display("FAIL busy_start_result: got %h required 6b", res_at_done); end
        tests++; if (busy_after !== 1'b0) begin fails++; $display("FAIL busy_start_restart: got busy=%b after done, required 0", busy_after); end
    endtask

    task automatic test_settle0();
        build_model(8'h81);
        run_conv(8'h81, 1'b1, 0);
        tests++; if (res_at_done !== 8'h81) begin fails++; $display("FAIL s0_result: got %h required 81", res_at_done); end
        tests++; if (done_cyc != exp_done_cyc(0)) begin fails++; $display("FAIL s0_done_cycle: got %0d required %0d", done_cyc, exp_done_cyc(0)); end
        tests++; if (trials.size() != W) begin fails++; $display("FAIL s0_trial_count: got %0d required %0d", trials.size(), W); end
        for (int i = 0; i < W; i++) begin
            tests++; if (trials[i] !== exp_trials[i] || trial_cyc[i] != exp_trial_cyc(i, 0)) begin fails++; $display("FAIL s0_trial[%0d]: got %h@%0d required %h@%0d", i, trials[i], trial_cyc[i], exp_trials[i], exp_trial_cyc(i, 0)); end
        end
        tests++; if (dac_at_done !== '0) begin fails++; $display("FAIL s0_dac_in_done: got %h required 00", dac_at_done); end
        sel_s0 = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        bit           use0;
        int           settle;
        for (int k = 0; k < 8; k++) begin
            v      = W'($urandom_range(0, 255));
            use0   = (k >= 5);
            settle = use0 ? 0 : 2;
            build_model(v);
            run_conv(v, use0, 0);
            tests++; if (res_at_done !== v) begin fails++; $display("FAIL rand_result[%0d]: got %h required %h", k, res_at_done, v); end
            tests++; if (done_cyc != exp_done_cyc(settle)) begin fails++; $display("FAIL rand_done_cycle[%0d]: got %0d required %0d", k, done_cyc, exp_done_cyc(settle)); end
            for (int i = 0; i < W; i++) begin
                tests++; if (trials[i] !== exp_trials[i]) begin fails++; $display("FAIL rand_trial[%0d][%0d]: got %h required %h", k, i, trials[i], exp_trials[i]); end
            end
        end
        sel_s0 = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; start0 = 1'b0;
        vin = '0; sel_s0 = 1'b0; mon_en = 1'b0;
        test_reset();
        mon_en = 1'b1;
        test_ideal_a5();
        test_extremes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_busy_ignore();
        test_settle0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
